// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM state encoding and
// the default generator counter width.
package pwm_capture_pkg;

    localparam int unsigned DEFAULT_N = 8;

    typedef enum logic [1:0] {
        SYNC = 2'b00,
        HIGH = 2'b01,
        LOW  = 2'b10
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a delayed copy
// used to detect rising and falling edges of the synchronized level.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic meta;
    logic s_d;

    // Synchronizer chain and one-cycle delayed copy of the synchronized level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            s    <= 1'b0;
            s_d  <= 1'b0;
        end else begin
            meta <= pwm_in;
            s    <= meta;
            s_d  <= s;
        end
    end

    // Edge strobes: synchronized level compared with its delayed copy.
    always_comb begin
        rise = s & ~s_d;
        fall = ~s & s_d;
    end

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of a PWM waveform in clk cycles.
// A partial period after reset or timeout is discarded; results are
// published with a one-cycle valid pulse at each complete period.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter  int unsigned N = DEFAULT_N,
    localparam int unsigned W = N + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pwm_in,
    output logic [W-1:0] high_time,
    output logic [W-1:0] period,
    output logic         valid,
    output logic         locked,
    output logic         stuck_high,
    output logic         stuck_low
);

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] pcnt;
    logic [W-1:0] hcap;
    logic         s;
    logic         rise;
    logic         fall;
    logic         restart;
    logic         timeout;

    sync_edge u_sync_edge (
        .clk    (clk),
        .reset  (reset),
        .pwm_in (pwm_in),
        .s      (s),
        .rise   (rise),
        .fall   (fall)
    );

    // Next-state logic; pcnt also runs in SYNC so a dead input times out,
    // and any edge seen in SYNC restarts the idle count.
    always_comb begin
        restart   = rise | ((state == SYNC) & fall);
        timeout   = (pcnt == '1) & ~restart;
        state_nxt = state;
        if (timeout) begin
            state_nxt = SYNC;
        end else begin
            case (state)
                SYNC:    if (rise) state_nxt = HIGH;
                HIGH:    if (fall) state_nxt = LOW;
                LOW:     if (rise) state_nxt = HIGH;
                default: state_nxt = SYNC;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Period counter, high-phase capture, published results and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt       <= '0;
            hcap       <= '0;
            high_time  <= '0;
            period     <= '0;
            valid      <= 1'b0;
            locked     <= 1'b0;
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
        end else begin
            valid <= 1'b0;

            // Counter saturates at its maximum instead of wrapping.
            if (restart) begin
                pcnt <= W'(1);
            end else if (!timeout) begin
                pcnt <= pcnt + 1'b1;
            end

            if (!timeout && state == HIGH && fall) begin
                hcap <= pcnt;
            end

            if (state == LOW && rise) begin
                period    <= pcnt;
                high_time <= hcap;
                valid     <= 1'b1;
                locked    <= 1'b1;
            end

            if (timeout) begin
                locked     <= 1'b0;
                stuck_high <= s;
                stuck_low  <= ~s;
            end else if (rise || fall) begin
                stuck_high <= 1'b0;
                stuck_low  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture. The reference model works on
// input edge times: every rise after the first one since (re)sync must
// yield a valid pulse two clocks after the edge that sampled the rise,
// reporting rise-to-rise and rise-to-fall distances.
module tb_pwm_capture;

    localparam int unsigned N = 8;
    localparam int unsigned W = N + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         pwm_in;
    logic [W-1:0] high_time;
    logic [W-1:0] period;
    logic         valid;
    logic         locked;
    logic         stuck_high;
    logic         stuck_low;

    always #5 clk = ~clk;

    pwm_capture #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .high_time  (high_time),
        .period     (period),
        .valid      (valid),
        .locked     (locked),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low)
    );

    typedef struct {
        int unsigned at;
        int unsigned per;
        int unsigned hi;
    } exp_t;

    typedef struct {
        int unsigned hi;
        int unsigned lo;
        int unsigned exp_hi;
        int unsigned exp_per;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        expq[$];
    int unsigned edge_n;
    bit          prev_v;
    bit          have_rise;
    int unsigned last_rise;
    int unsigned last_fall;
    int unsigned seen_hi;
    int unsigned seen_per;
    int unsigned nvalid;
    vec_t        vecs[6];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic model_resync();
        have_rise = 1'b0;
        expq.delete();
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        prev_v   = 1'b0;
        edge_n   = 0;
        seen_hi  = 0;
        seen_per = 0;
        nvalid   = 0;
        model_resync();
    endtask

    // Apply one clock of input, advance the model, and check the outputs.
    task automatic drive(input bit v);
        exp_t e;
        pwm_in = v;
        @(posedge clk);
        edge_n++;
        if (v && !prev_v) begin
            if (have_rise) begin
                e.at  = edge_n + 2;
                e.per = edge_n - last_rise;
                e.hi  = last_fall - last_rise;
                expq.push_back(e);
            end
            last_rise = edge_n;
            have_rise = 1'b1;
        end
        if (!v && prev_v) last_fall = edge_n;
        prev_v = v;
        #1;
        if (expq.size() > 0 && expq[0].at == edge_n) begin
            check("valid", valid, 1);
            check("period", period, expq[0].per);
            check("high_time", high_time, expq[0].hi);
            void'(expq.pop_front());
        end else begin
            check("no_valid", valid, 0);
        end
        check("stuck_excl", stuck_high & stuck_low, 0);
        if (valid) begin
            seen_hi  = high_time;
            seen_per = period;
            nvalid++;
        end
    endtask

    task automatic run_pattern(input int unsigned hi, input int unsigned lo, input int unsigned reps);
        repeat (reps) begin
            repeat (hi) drive(1'b1);
            repeat (lo) drive(1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_high_time"}, high_time, 0);
        check({tag, "_period"}, period, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_stuck_high"}, stuck_high, 0);
        check({tag, "_stuck_low"}, stuck_low, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{hi: 3,   lo: 5,   exp_hi: 3,   exp_per: 8};
        vecs[1] = '{hi: 64,  lo: 192, exp_hi: 64,  exp_per: 256};
        vecs[2] = '{hi: 1,   lo: 1,   exp_hi: 1,   exp_per: 2};
        vecs[3] = '{hi: 1,   lo: 7,   exp_hi: 1,   exp_per: 8};
        vecs[4] = '{hi: 7,   lo: 1,   exp_hi: 7,   exp_per: 8};
        vecs[5] = '{hi: 200, lo: 56,  exp_hi: 200, exp_per: 256};

        // Reset state.
        do_reset();
        check_all_zero("rst");

        // Table of steady patterns: three full periods plus a closing rise.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            run_pattern(vecs[i].hi, vecs[i].lo, 3);
            repeat (3) drive(1'b1);
            check("tbl_high_time", seen_hi, vecs[i].exp_hi);
            check("tbl_period", seen_per, vecs[i].exp_per);
            check("tbl_nvalid", nvalid, 3);
            check("tbl_locked", locked, 1);
        end

        // Constant low from reset: stuck_low after the counter saturates.
        do_reset();
        repeat (510) drive(1'b0);
        check("low_early_stuck_low", stuck_low, 0);
        repeat (5) drive(1'b0);
        check("low_stuck_low", stuck_low, 1);
        check("low_stuck_high", stuck_high, 0);
        check("low_locked", locked, 0);
        repeat (4) drive(1'b1);
        check("low_clear_stuck_low", stuck_low, 0);
        check("low_no_valid_first_rise", nvalid, 0);
        repeat (4) drive(1'b0);
        run_pattern(3, 5, 2);
        repeat (3) drive(1'b1);
        check("low_resume_nvalid", nvalid, 3);
        check("low_resume_period", seen_per, 8);
        check("low_resume_high", seen_hi, 3);

        // Constant high after lock: stuck_high, results held.
        do_reset();
        run_pattern(10, 10, 3);
        check("hi_locked_before", locked, 1);
        repeat (520) drive(1'b1);
        check("hi_stuck_high", stuck_high, 1);
        check("hi_stuck_low", stuck_low, 0);
        check("hi_locked", locked, 0);
        check("hi_hold_high_time", high_time, 10);
        check("hi_hold_period", period, 20);
        model_resync();
        nvalid = 0;
        repeat (4) drive(1'b0);
        check("hi_clear_stuck_high", stuck_high, 0);
        run_pattern(10, 10, 2);
        repeat (3) drive(1'b1);
        check("hi_resume_nvalid", nvalid, 2);
        check("hi_resume_locked", locked, 1);

        // Reset in the middle of a high phase.
        do_reset();
        run_pattern(20, 30, 2);
        repeat (10) drive(1'b1);
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        do_reset();
        run_pattern(20, 30, 2);
        repeat (3) drive(1'b1);
        check("midrst_high_time", seen_hi, 20);
        check("midrst_period", seen_per, 50);
        check("midrst_nvalid", nvalid, 2);

        // Duty change 64 -> 200 on a period boundary.
        do_reset();
        run_pattern(64, 192, 3);
        nvalid = 0;
        run_pattern(200, 56, 3);
        repeat (3) drive(1'b1);
        check("duty_high_time", seen_hi, 200);
        check("duty_period", seen_per, 256);
        check("duty_nvalid", nvalid, 4);

        // Randomized phases against the edge-time model.
        do_reset();
        repeat (150) begin
            run_pattern($urandom_range(40, 1), $urandom_range(40, 1), 1);
        end
        repeat (3) drive(1'b1);
        check("rand_pending", expq.size(), 0);
        check("rand_locked", locked, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
